id_ex_operand_stage: RTL

- ID/EX pipeline boundary that consumes forwardA/forwardB from forwarding_unit.
- Applies the forwarding selects to the ID-stage operand values and registers the selected operands, with control, into the EX stage.
- Owns the load-use interlock: stalls ID and inserts EX bubbles when a load in EX targets a source register of the instruction in ID.
- Also handles flush (taken branch) bubbles.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/operand_fwd_mux.sv | 26 ++
 rtl/id_ex_operand_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: forwarding selects, ID/EX interlock states, width defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 4;

  // Forwarding select encoding shared with forwarding_unit; 2'b11 is never produced
  // by the forwarding unit and is treated as a regfile read.
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // RUN: normal flow; STALL: extra load-use bubbles; DRAIN: release cycle after a stall.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } stageState_t;

  // Saturating 16-bit increment for event counters.
  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Combinational 3:1 operand select between regfile, EX/MEM and MEM/WB values.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs every cycle.
module operand_fwd_mux
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [1:0]    fwdSel,
  input  logic [DW-1:0] regData,
  input  logic [DW-1:0] exMemData,
  input  logic [DW-1:0] memWbData,
  output logic [DW-1:0] operand
);

  // Unused encoding 2'b11 falls through to the regfile value so the operand is never X.
  always_comb begin
    operand = regData;
    case (fwdSel)
      FWD_EXMEM: operand = exMemData;
      FWD_MEMWB: operand = memWbData;
      default:   operand = regData;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX boundary: forwards operands, registers them into EX, owns load-use interlock and flush bubbles.
// Latency: 1 cycle from ID inputs to ex_* outputs; stall_id is combinational in the ID cycle.
// Backpressure: stall_id holds PC and IF/ID for LOAD_STALL_CYCLES cycles per load-use hazard; flush overrides.
// Optional feature: define FWD_STATS_EN to add saturating fwd_count/stall_count outputs.
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DW                = DW_DEF,
  parameter int RW                = RW_DEF,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [3:0]    id_opcode,
  input  logic [RW-1:0] id_op1_reg,
  input  logic [RW-1:0] id_op2_reg,
  input  logic [DW-1:0] id_op1_data,
  input  logic [DW-1:0] id_op2_data,
  input  logic          id_is_load,
  input  logic          id_reg_write,
  input  logic [1:0]    forwardA,
  input  logic [1:0]    forwardB,
  input  logic [DW-1:0] ex_mem_result,
  input  logic [DW-1:0] mem_wb_result,
  input  logic          flush,
  output logic          stall_id,
  output logic          ex_valid,
  output logic [3:0]    ex_opcode,
  output logic [RW-1:0] ex_op1_reg,
  output logic [DW-1:0] ex_op1_val,
  output logic [DW-1:0] ex_op2_val,
  output logic          ex_is_load,
  output logic          ex_reg_write
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]   fwd_count,
  output logic [15:0]   stall_count
`endif
);

  // First hazard cycle happens in RUN, so the counter only covers the remaining bubbles.
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  stageState_t   state, stateNext;
  logic [2:0]    stallCnt, stallCntNext;
  logic          hazard;
  logic          holdId;
  logic          latchId;
  logic [DW-1:0] opA, opB;

  operand_fwd_mux #(.DW(DW)) muxA (
    .fwdSel    (forwardA),
    .regData   (id_op1_data),
    .exMemData (ex_mem_result),
    .memWbData (mem_wb_result),
    .operand   (opA)
  );

  operand_fwd_mux #(.DW(DW)) muxB (
    .fwdSel    (forwardB),
    .regData   (id_op2_data),
    .exMemData (ex_mem_result),
    .memWbData (mem_wb_result),
    .operand   (opB)
  );

  // A load sitting in EX whose destination is read by the instruction in ID.
  assign hazard = ex_valid & ex_is_load & ex_reg_write & id_valid &
                  ((ex_op1_reg == id_op1_reg) | (ex_op1_reg == id_op2_reg));

  // Interlock state and bubble counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      stallCnt <= 3'd0;
    end else begin
      state    <= stateNext;
      stallCnt <= stallCntNext;
    end
  end

  // Next-state: flush wins everywhere; DRAIN never re-checks the hazard.
  always_comb begin
    stateNext    = state;
    stallCntNext = stallCnt;
    if (flush) begin
      stateNext    = RUN;
      stallCntNext = 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            stallCntNext = STALL_RELOAD;
            stateNext    = (STALL_RELOAD == 3'd0) ? DRAIN : STALL;
          end
        end
        STALL: begin
          if (stallCnt <= 3'd1) begin
            stallCntNext = 3'd0;
            stateNext    = DRAIN;
          end else begin
            stallCntNext = stallCnt - 3'd1;
          end
        end
        default: begin
          stateNext = RUN;
        end
      endcase
    end
  end

  // Outputs of the interlock: hold ID while stalling, otherwise let a valid ID instruction through.
  always_comb begin
    holdId = 1'b0;
    case (state)
      RUN:     holdId = hazard;
      STALL:   holdId = 1'b1;
      default: holdId = 1'b0;
    endcase
    if (flush) holdId = 1'b0;
    stall_id = holdId & ~rst;
    latchId  = id_valid & ~holdId & ~flush;
  end

  // EX register: bubbles clear only the qualifiers, data/index fields keep their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= '0;
      ex_op1_reg   <= '0;
      ex_op1_val   <= '0;
      ex_op2_val   <= '0;
      ex_is_load   <= 1'b0;
      ex_reg_write <= 1'b0;
    end else begin
      ex_valid     <= latchId;
      ex_is_load   <= latchId & id_is_load;
      ex_reg_write <= latchId & id_reg_write;
      if (latchId) begin
        ex_opcode  <= id_opcode;
        ex_op1_reg <= id_op1_reg;
        ex_op1_val <= opA;
        ex_op2_val <= opB;
      end
    end
  end

`ifdef FWD_STATS_EN
  // Forwarded-instruction and hazard-bubble counters, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_count   <= 16'd0;
      stall_count <= 16'd0;
    end else begin
      if (latchId && ((forwardA != FWD_REG) || (forwardB != FWD_REG)))
        fwd_count <= satInc16(fwd_count);
      if (stall_id)
        stall_count <= satInc16(stall_count);
    end
  end
`endif

endmodule
